// File: rtl/uart_srv_pkg.sv
// Shared types and constants for the UART instruction server.
package uart_srv_pkg;

  typedef enum logic [1:0] {
    RX_WORD,
    LOOKUP,
    CAPTURE,
    TX_WORD
  } srv_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int BYTES_PER_WORD       = 4;
  localparam int BITS_PER_FRAME       = 10;
  localparam int DEFAULT_BAUD_DIV     = 163;
  localparam int DEFAULT_TIMEOUT_BITS = 32;

endpackage

// File: rtl/uart_srv_byte_rx.sv
// 8N1 byte receiver: rx synchronizer, start validation, mid-bit sampling, stop check.
module uart_srv_byte_rx
  import uart_srv_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  input  logic       en_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       start_edge_o,
  output logic       active_o
);

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        valid_q, err_q;

  assign start_edge_o = rx_prev_q & ~rx_sync_q;
  assign active_o     = (state_q != RX_IDLE);
  assign byte_o       = shift_q;
  assign valid_o      = valid_q;
  assign err_o        = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (en_i && start_edge_o) begin
            state_q <= RX_START;
            baud_q  <= 16'(BAUD_DIV / 2 - 1);
          end
        end
        RX_START: begin
          if (baud_q != 0) begin
            baud_q <= baud_q - 16'd1;
          end else if (rx_sync_q) begin
            // Line went back high at mid-start: a glitch, drop it silently.
            state_q <= RX_IDLE;
          end else begin
            state_q <= RX_DATA;
            baud_q  <= 16'(BAUD_DIV - 1);
            bit_q   <= '0;
          end
        end
        RX_DATA: begin
          if (baud_q != 0) begin
            baud_q <= baud_q - 16'd1;
          end else begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            baud_q  <= 16'(BAUD_DIV - 1);
            if (bit_q == 3'd7) state_q <= RX_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end
        end
        RX_STOP: begin
          if (baud_q != 0) begin
            baud_q <= baud_q - 16'd1;
          end else begin
            state_q <= RX_IDLE;
            if (rx_sync_q) valid_q <= 1'b1;
            else           err_q   <= 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_instr_server.sv
// Receives a 32-bit address over UART, reads instruction memory, returns the word.
module uart_instr_server
  import uart_srv_pkg::*;
#(
  parameter int BAUD_DIV     = DEFAULT_BAUD_DIV,
  parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        frame_err,
  output logic        rx_overrun
);

  localparam logic [31:0] GAP_LIMIT = 32'(TIMEOUT_BITS * BAUD_DIV);

  srv_state_e  state_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] word_q;
  logic [31:0] gap_q;
  logic [31:0] tx_data_q;
  logic [3:0]  tx_bit_q;
  logic [1:0]  tx_byte_q;
  logic [15:0] tx_baud_q;
  logic        tx_q, busy_q, mem_rd_q, frame_err_q, rx_overrun_q;
  logic [31:0] mem_addr_q;

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_err, rx_start_edge, rx_active;

  uart_srv_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx),
    .en_i         (~busy_q),
    .byte_o       (rx_byte),
    .valid_o      (rx_valid),
    .err_o        (rx_err),
    .start_edge_o (rx_start_edge),
    .active_o     (rx_active)
  );

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign frame_err  = frame_err_q;
  assign rx_overrun = rx_overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RX_WORD;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      gap_q        <= '0;
      tx_data_q    <= '0;
      tx_bit_q     <= '0;
      tx_byte_q    <= '0;
      tx_baud_q    <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      mem_rd_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= busy_q & rx_start_edge;
      case (state_q)
        RX_WORD: begin
          if (rx_err) begin
            frame_err_q <= 1'b1;
            byte_cnt_q  <= '0;
            gap_q       <= '0;
          end else if (rx_valid) begin
            gap_q <= '0;
            if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
              state_q    <= LOOKUP;
              busy_q     <= 1'b1;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= {rx_byte, word_q};
              byte_cnt_q <= '0;
            end else begin
              word_q[{byte_cnt_q, 3'b000} +: 8] <= rx_byte;
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end else if (byte_cnt_q != 0 && !rx_active) begin
            // Idle gap inside a word; too long means the CPU gave up mid-word.
            if (gap_q == GAP_LIMIT) begin
              frame_err_q <= 1'b1;
              byte_cnt_q  <= '0;
              gap_q       <= '0;
            end else begin
              gap_q <= gap_q + 32'd1;
            end
          end
        end
        LOOKUP: state_q <= CAPTURE;
        CAPTURE: begin
          tx_data_q <= mem_rdata;
          tx_q      <= 1'b0;
          tx_bit_q  <= '0;
          tx_byte_q <= '0;
          tx_baud_q <= 16'(BAUD_DIV - 1);
          state_q   <= TX_WORD;
        end
        TX_WORD: begin
          if (tx_baud_q != 0) begin
            tx_baud_q <= tx_baud_q - 16'd1;
          end else begin
            tx_baud_q <= 16'(BAUD_DIV - 1);
            if (tx_bit_q == 4'(BITS_PER_FRAME - 1)) begin
              if (tx_byte_q == 2'(BYTES_PER_WORD - 1)) begin
                state_q    <= RX_WORD;
                busy_q     <= 1'b0;
                tx_q       <= 1'b1;
                gap_q      <= '0;
                byte_cnt_q <= '0;
              end else begin
                tx_byte_q <= tx_byte_q + 2'd1;
                tx_bit_q  <= '0;
                tx_q      <= 1'b0;
                tx_data_q <= {8'h00, tx_data_q[31:8]};
              end
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
              tx_q     <= (tx_bit_q == 4'd8) ? 1'b1 : tx_data_q[tx_bit_q[2:0]];
            end
          end
        end
        default: state_q <= RX_WORD;
      endcase
    end
  end

endmodule
